kv_responder: RTL and testbench
===============================

KV_RESPONDER -- requirements
Module: kv_responder

Interface
REQ-001 The parameters SHALL be:
- KEY_SIZE, default 96, lookup key width.
- IDX_BITS, default 8, table index width; table depth is 2^IDX_BITS.
REQ-002 The ports SHALL be:
- clk156  in  1  sole clock; all logic on its rising edge.
- eth_rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  one request per asserted cycle.
- in_key  in  KEY_SIZE  request key, sampled when in_valid=1.
- in_flag  in  4  request op; [2:1]=status code, [3] and [0] ignored.
- out_valid  out  1  one-cycle response pulse.
- out_flag  out  4  response; {1'b0, status[1:0], hit}.
- busy  out  1  table initialisation in progress; requests dropped.
- debug  out  8  {busy, drop_seen, hit_cnt[5:0]}.

Function
REQ-003 The table SHALL hold 2^IDX_BITS direct-mapped entries, each {valid, tag[KEY_SIZE-1:0], status[1:0]}, in a 1-cycle-read RAM.
REQ-004 The index SHALL be the XOR of all IDX_BITS-wide slices of in_key, LSB-aligned; the top slice is zero-padded when KEY_SIZE is not a multiple of IDX_BITS.
REQ-005 State machine SHALL have states INIT and RUN; reset enters INIT with the clear pointer at 0.
REQ-006 INIT SHALL write valid=0 to one entry per cycle, pointer 0..2^IDX_BITS-1, then go to RUN; busy=1 exactly throughout INIT.
REQ-007 A request with in_valid=1 while busy=1 SHALL be dropped with no response and SHALL set drop_seen (sticky until reset).
REQ-008 In RUN, a request with in_flag[2:1]=00 SHALL be ignored: no response and no table change.
REQ-009 Hit SHALL mean entry valid=1 and tag==in_key.
REQ-010 SUSPECT (01):
- Miss: write {1, key, 01}, overwriting any previous occupant.
- Hit with status 01: write nothing.
- Hit with status 10: keep status 10; never downgrade.
- Response: {0, resulting status, hit}.
REQ-011 ARREST (10):
- Hit: write status 10; respond {0,10,1}.
- Miss: no write; respond {0,00,0}.
REQ-012 FILTER (11):
- Hit: clear valid.
- Response: {0,11,hit}.
REQ-013 Pipeline: S1 latches key/op/index and issues the RAM read; S2 receives RAM data; S3 compares, writes the RAM and drives the response.
REQ-014 out_valid SHALL assert exactly 3 cycles after the accepted in_valid cycle; throughput is one request per cycle with no stalls.
REQ-015 Results SHALL equal strictly sequential processing in arrival order, including back-to-back same-index requests. Forwarding from the S3 write and the pending write SHALL override stale RAM data.
REQ-016 out_flag SHALL be 0 whenever out_valid=0.
REQ-017 hit_cnt SHALL increment, wrapping at 6 bits, on every response with hit=1.

Reset
REQ-018 eth_rst=1 SHALL clear the following in the same edge:
- the pipeline, with no response for in-flight requests;
- out_valid, out_flag, hit_cnt and drop_seen to 0.
REQ-019 After eth_rst, busy SHALL be 1 from the first cycle following the reset edge, and INIT SHALL restart from pointer 0.
REQ-020 Reset asserted during INIT or RUN SHALL restart the full clear; no entry written before reset may hit afterwards.

Verification
REQ-021 Reset, then count cycles -> busy=1 for exactly 256 cycles; requests issued during that window give no out_valid and debug[6]=1.
REQ-022 SUSPECT key K=96'h0A000001_0A000002_3039_0000 at cycle t -> out_valid at t+3 with out_flag=4'b0010. A following ARREST K -> out_flag=4'b0101. A further SUSPECT K -> out_flag=4'b0101.
REQ-023 ARREST on an unseen key -> out_flag=4'b0000. A later SUSPECT of the same key -> 4'b0010, showing the miss wrote nothing.
REQ-024 SUSPECT K, ARREST K, FILTER K, ARREST K on consecutive cycles -> responses on 4 consecutive cycles: 0010, 0101, 0111, 0000. This exercises forwarding.
REQ-025 Two keys with equal index (K1, K2): SUSPECT K1, SUSPECT K2, ARREST K1 -> 0010, 0010, 0000, showing eviction.
REQ-026 Assert eth_rst for one cycle while three requests are in flight -> no out_valid follows; busy rises; a prior SUSPECT key then misses on ARREST after INIT.

Source files
------------

// File: rtl/kv_responder.sv
// kv_responder: direct-mapped key/status table with a three-stage
// request/response pipeline.
//
// Ports:
//   clk156    in   sole clock, rising edge
//   eth_rst   in   synchronous active-high reset
//   in_valid  in   one request per asserted cycle
//   in_key    in   request key [KEY_SIZE-1:0]
//   in_flag   in   request op, [2:1] = status code (01 suspect, 10 arrest, 11 filter)
//   out_valid out  one-cycle response pulse, 3 cycles after the request
//   out_flag  out  {1'b0, status[1:0], hit}, zero when out_valid is low
//   busy      out  table clear in progress; requests are dropped
//   debug     out  {busy, drop_seen, hit_cnt[5:0]}
module kv_responder #(
    parameter int KEY_SIZE = 96,
    parameter int IDX_BITS = 8
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic                in_valid,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                busy,
    output logic [7:0]          debug
);
    localparam int DEPTH  = 1 << IDX_BITS;
    localparam int ENT_W  = KEY_SIZE + 3;  // {valid, tag, status}
    localparam int NSLICE = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
    localparam int PAD_W  = NSLICE * IDX_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [IDX_BITS-1:0] fold_index(input logic [KEY_SIZE-1:0] key);
        logic [PAD_W-1:0]    padded;
        logic [IDX_BITS-1:0] acc;
        padded = PAD_W'(key);
        acc    = '0;
        for (int i = 0; i < NSLICE; i++) begin
            acc ^= padded[i*IDX_BITS +: IDX_BITS];
        end
        return acc;
    endfunction

    state_t              r_state;
    logic [IDX_BITS-1:0] r_clr_ptr;
    logic                r_busy;
    logic                r_drop_seen;
    logic [5:0]          r_hit_cnt;

    logic                r_vld_p0;
    logic [KEY_SIZE-1:0] r_key_p0;
    logic [1:0]          r_op_p0;
    logic [IDX_BITS-1:0] r_idx_p0;

    logic                r_vld_p1;
    logic [KEY_SIZE-1:0] r_key_p1;
    logic [1:0]          r_op_p1;
    logic [IDX_BITS-1:0] r_idx_p1;
    logic [ENT_W-1:0]    r_ram_q_p1;
    logic                r_fwd_p1;
    logic [ENT_W-1:0]    r_fwd_ent_p1;

    logic                r_out_valid;
    logic [3:0]          r_out_flag;

    logic [ENT_W-1:0]    r_mem [DEPTH];

    logic [IDX_BITS-1:0] w_idx;
    logic                w_accept;
    logic [ENT_W-1:0]    w_ent;
    logic                w_hit;
    logic [1:0]          w_cur_st;
    logic                w_s3_we;
    logic [ENT_W-1:0]    w_s3_wdata;
    logic [3:0]          w_resp;
    logic                w_we;
    logic [IDX_BITS-1:0] w_waddr;
    logic [ENT_W-1:0]    w_wdata;
    logic                w_unused_flag_bits;

    assign w_unused_flag_bits = in_flag[3] ^ in_flag[0];

    assign w_idx    = fold_index(in_key);
    // Status code 00 is a no-op, so it never enters the pipeline.
    assign w_accept = in_valid && !r_busy && (in_flag[2:1] != 2'b00);

    // Control FSM: INIT walks the clear pointer over every entry, then RUN.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state     <= ST_INIT;
            r_clr_ptr   <= '0;
            r_busy      <= 1'b1;
            r_drop_seen <= 1'b0;
        end else begin
            if (in_valid && r_busy) begin
                r_drop_seen <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (&r_clr_ptr) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- S1 -> S2: request latched, RAM read issued from r_idx_p0 ----
    always_ff @(posedge clk156) begin
        r_key_p0 <= in_key;
        r_op_p0  <= in_flag[2:1];
        r_idx_p0 <= w_idx;
        r_key_p1 <= r_key_p0;
        r_op_p1  <= r_op_p0;
        r_idx_p1 <= r_idx_p0;
        // The S3 write landing on this same edge is invisible to the RAM
        // read, so remember it and let it override the stale read data.
        r_fwd_p1     <= w_s3_we && (r_idx_p1 == r_idx_p0);
        r_fwd_ent_p1 <= w_s3_wdata;
    end

    // Single write port shared by the INIT clear and the S3 update.
    assign w_we    = (r_state == ST_INIT) || (w_s3_we && !eth_rst);
    assign w_waddr = (r_state == ST_INIT) ? r_clr_ptr : r_idx_p1;
    assign w_wdata = (r_state == ST_INIT) ? '0 : w_s3_wdata;

    always_ff @(posedge clk156) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_ram_q_p1 <= r_mem[r_idx_p0];
    end

    // ---- S3: compare, decide write and response ----
    assign w_ent    = r_fwd_p1 ? r_fwd_ent_p1 : r_ram_q_p1;
    assign w_hit    = w_ent[ENT_W-1] && (w_ent[KEY_SIZE+1:2] == r_key_p1);
    assign w_cur_st = w_ent[1:0];

    always_comb begin
        w_s3_we    = 1'b0;
        w_s3_wdata = w_ent;
        w_resp     = 4'b0000;
        if (r_vld_p1) begin
            case (r_op_p1)
                2'b01: begin
                    if (!w_hit) begin
                        w_s3_we    = 1'b1;
                        w_s3_wdata = {1'b1, r_key_p1, 2'b01};
                        w_resp     = 4'b0010;
                    end else begin
                        // An arrested entry is never downgraded.
                        w_resp = {1'b0, w_cur_st, 1'b1};
                    end
                end
                2'b10: begin
                    if (w_hit) begin
                        w_s3_we    = 1'b1;
                        w_s3_wdata = {1'b1, r_key_p1, 2'b10};
                        w_resp     = 4'b0101;
                    end
                end
                2'b11: begin
                    if (w_hit) begin
                        w_s3_we    = 1'b1;
                        w_s3_wdata = {1'b0, w_ent[ENT_W-2:0]};
                    end
                    w_resp = {1'b0, 2'b11, w_hit};
                end
                default: ;
            endcase
        end
    end

    // ---- S3 -> output: registered response ----
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_flag  <= 4'b0000;
            r_hit_cnt   <= 6'd0;
        end else begin
            r_vld_p0    <= w_accept;
            r_vld_p1    <= r_vld_p0;
            r_out_valid <= r_vld_p1;
            r_out_flag  <= r_vld_p1 ? w_resp : 4'b0000;
            if (r_vld_p1 && w_hit) begin
                r_hit_cnt <= r_hit_cnt + 6'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_flag  = r_out_flag;
    assign busy      = r_busy;
    assign debug     = {r_busy, r_drop_seen, r_hit_cnt};

endmodule

// File: tb/tb_kv_responder.sv
// tb_kv_responder: directed and randomized checks of kv_responder against a
// sequential table model (arrays indexed by the folded key, responses queued
// with the cycle they are due).
module tb_kv_responder;
    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic        in_valid;
    logic [95:0] in_key;
    logic [3:0]  in_flag;
    logic        out_valid;
    logic [3:0]  out_flag;
    logic        busy;
    logic [7:0]  debug;

    always #5 clk156 = ~clk156;

    kv_responder #(.KEY_SIZE(96), .IDX_BITS(8)) dut (
        .clk156   (clk156),
        .eth_rst  (eth_rst),
        .in_valid (in_valid),
        .in_key   (in_key),
        .in_flag  (in_flag),
        .out_valid(out_valid),
        .out_flag (out_flag),
        .busy     (busy),
        .debug    (debug)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference table: what sequential processing leaves behind.
    bit          m_valid [256];
    logic [95:0] m_tag   [256];
    logic [1:0]  m_st    [256];
    int          m_busy_cnt = 0;
    bit          m_drop = 0;
    int          m_hits = 0;

    typedef struct {
        int         due;
        logic [3:0] flag;
    } exp_t;
    exp_t       pend[$];
    logic [3:0] rlog[$];

    logic [95:0] pool [8];

    function automatic int m_index(input logic [95:0] k);
        int a = 0;
        for (int i = 0; i < 12; i++) a = a ^ int'((k >> (8 * i)) & 96'hFF);
        return a;
    endfunction

    function automatic logic [3:0] m_apply(input logic [95:0] k, input logic [1:0] op);
        int ix;
        bit hit;
        ix  = m_index(k);
        hit = m_valid[ix] && (m_tag[ix] == k);
        case (op)
            2'b01: begin
                if (!hit) begin
                    m_valid[ix] = 1'b1;
                    m_tag[ix]   = k;
                    m_st[ix]    = 2'b01;
                end
                return {1'b0, m_st[ix], hit};
            end
            2'b10: begin
                if (hit) begin
                    m_st[ix] = 2'b10;
                    return 4'b0101;
                end
                return 4'b0000;
            end
            2'b11: begin
                if (hit) m_valid[ix] = 1'b0;
                return {1'b0, 2'b11, hit};
            end
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [3:0] ef;
        exp_t       e;
        ev = 1'b0;
        ef = 4'b0000;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e  = pend.pop_front();
            ev = 1'b1;
            ef = e.flag;
            if (ef[0]) m_hits++;
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("out_flag", {28'd0, out_flag}, {28'd0, ef});
        chk("busy", {31'd0, busy}, {31'd0, m_busy_cnt > 0});
        chk("debug", {24'd0, debug}, {24'd0, (m_busy_cnt > 0), m_drop, 6'(m_hits)});
        if (out_valid === 1'b1) rlog.push_back(out_flag);
    endtask

    task automatic step(input logic v, input logic [95:0] k, input logic [3:0] f);
        exp_t e;
        eth_rst  = 1'b0;
        in_valid = v;
        in_key   = k;
        in_flag  = f;
        if (v) begin
            if (m_busy_cnt > 0) begin
                m_drop = 1'b1;
            end else if (f[2:1] != 2'b00) begin
                e.due  = cyc + 3;
                e.flag = m_apply(k, f[2:1]);
                pend.push_back(e);
            end
        end
        @(posedge clk156);
        cyc++;
        if (m_busy_cnt > 0) m_busy_cnt--;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 96'd0, 4'd0);
    endtask

    task automatic do_reset(input logic v, input logic [95:0] k, input logic [3:0] f);
        eth_rst  = 1'b1;
        in_valid = v;
        in_key   = k;
        in_flag  = f;
        @(posedge clk156);
        cyc++;
        m_busy_cnt = 256;
        pend.delete();
        m_drop = 1'b0;
        m_hits = 0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        #1;
        check_outputs();
        eth_rst  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_init();
        int g;
        g = 0;
        while (busy === 1'b1 && g < 400) begin
            step(1'b0, 96'd0, 4'd0);
            g++;
        end
        chk("init_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_log(input string tag, input int n, input logic [15:0] exp);
        chk({tag, "_count"}, rlog.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rlog.size())
                chk($sformatf("%s_%0d", tag, i), {28'd0, rlog[i]}, {28'd0, exp[4*(n-1-i) +: 4]});
        end
        rlog.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] K, U, K1, K2, K3, K4;
        int          busy_cycles;
        logic        v;
        logic [3:0]  f;

        K  = 96'h0A000001_0A000002_3039_0000;
        U  = 96'hDEAD0000_BEEF0000_12345678;
        K3 = 96'h0A000001_0A000002_3039_0001;
        K1 = 96'hC0A80001_C0A80002_0050_1F90;
        K2 = K1 ^ 96'h5A5A;              // same folded index as K1
        K4 = 96'h11112222_33334444_55556666;
        pool[0] = K;  pool[1] = U;  pool[2] = K1; pool[3] = K2;
        pool[4] = K3; pool[5] = K4;
        pool[6] = K1 ^ 96'h3C3C_0000;    // also collides with K1
        pool[7] = {$urandom(), $urandom(), $urandom()};

        eth_rst  = 1'b0;
        in_valid = 1'b0;
        in_key   = '0;
        in_flag  = '0;

        do_reset(1'b0, 96'd0, 4'd0);

        // Busy window length, with requests thrown at it.
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 300) begin
            busy_cycles++;
            step(1'b1, {$urandom(), $urandom(), $urandom()}, 4'b0010);
        end
        chk("busy_len", busy_cycles, 256);
        chk("drop_seen", {31'd0, debug[6]}, 32'd1);
        idle(3);
        chk("no_resp_during_init", rlog.size(), 0);
        rlog.delete();

        // Suspect, arrest, suspect again (no downgrade); ignored flag bits set.
        step(1'b1, K, 4'b0010);
        step(1'b1, K, 4'b1101);
        step(1'b1, K, 4'b1011);
        idle(4);
        chk_log("basic", 3, 16'h0255);

        // Arrest of an unseen key writes nothing.
        step(1'b1, U, 4'b0100);
        idle(1);
        step(1'b1, U, 4'b0010);
        idle(4);
        chk_log("arrest_miss", 2, 16'h0002);

        // Back-to-back same key exercises forwarding.
        step(1'b1, K3, 4'b0010);
        step(1'b1, K3, 4'b0100);
        step(1'b1, K3, 4'b0110);
        step(1'b1, K3, 4'b0100);
        idle(4);
        chk_log("forward", 4, 16'h2570);

        // Eviction on index collision.
        step(1'b1, K1, 4'b0010);
        step(1'b1, K2, 4'b0010);
        step(1'b1, K1, 4'b0100);
        idle(4);
        chk_log("evict", 3, 16'h0220);

        // Opcode 00 is ignored entirely.
        step(1'b1, K2, 4'b1001);
        idle(4);
        chk("op00_ignored", rlog.size(), 0);

        // Reset with requests in flight.
        step(1'b1, K4, 4'b0010);
        idle(4);
        rlog.delete();
        step(1'b1, pool[7], 4'b0010);
        step(1'b1, K, 4'b0100);
        do_reset(1'b1, K3, 4'b0010);
        idle(5);
        chk("reset_drops_inflight", rlog.size(), 0);
        wait_init();
        rlog.delete();
        step(1'b1, K4, 4'b0100);
        idle(4);
        chk_log("post_reset_miss", 1, 16'h0000);

        // Randomized traffic over a small key pool, with one mid-run reset.
        for (int i = 0; i < 900; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = 4'($urandom_range(0, 15));
            if (i == 450) begin
                do_reset(v, pool[$urandom_range(0, 7)], f);
            end else begin
                step(v, pool[$urandom_range(0, 7)], f);
            end
        end
        idle(4);
        chk("pending_drained", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
